mul_div_seq_8bit: RTL and testbench

MUL_DIV_SEQ_8BIT -- requirements
Module: mul_div_seq_8bit

---
 rtl/mul_div_pkg.sv | 20 ++
 rtl/add_sub_8bit.sv | 18 +
 rtl/mul_div_seq_8bit.sv | 137 +++++++++++++
 tb/tb_mul_div_seq_8bit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared definitions for the sequential 8-bit multiply/divide block:
// FSM state encoding, iteration count and operation-select constants.
package mul_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int ITER  = 8;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

endpackage : mul_div_pkg

// File: rtl/add_sub_8bit.sv
// 8-bit ripple add/subtract. With i_sub=1 it computes a-b as a+~b+1, so
// o_carry=1 means "no borrow" (a >= b unsigned).
module add_sub_8bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_sub,
    output logic [7:0] o_sum,
    output logic       o_carry,
    output logic       o_overflow
);

    logic [7:0] w_b;

    assign w_b                = i_sub ? ~i_b : i_b;
    assign {o_carry, o_sum}   = {1'b0, i_a} + {1'b0, w_b} + {8'd0, i_sub};
    assign o_overflow         = (i_a[7] == w_b[7]) && (o_sum[7] != i_a[7]);

endmodule : add_sub_8bit

// File: rtl/mul_div_seq_8bit.sv
// Sequential unsigned 8x8 multiply (shift-add) and 8/8 divide (restoring),
// one bit per cycle through a single shared add/subtract datapath.
module mul_div_seq_8bit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_mode;
    logic [WIDTH-1:0]   r_m;        // multiplicand or divisor
    logic [WIDTH-1:0]   r_acc;      // accumulator or partial remainder
    logic [WIDTH-1:0]   r_q;        // multiplier or dividend/quotient
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result_hi;
    logic [WIDTH-1:0]   r_result_lo;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_add_a;
    logic [WIDTH-1:0]   w_sum;
    logic               w_carry;
    logic               w_unused_overflow;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_q_nxt;

    // Divide feeds the adder the left-shifted remainder; multiply feeds acc.
    assign w_add_a = (r_mode == MODE_DIV) ? {r_acc[WIDTH-2:0], r_q[WIDTH-1]} : r_acc;

    add_sub_8bit u_add_sub (
        .i_a        (w_add_a),
        .i_b        (r_m),
        .i_sub      (r_mode),
        .o_sum      (w_sum),
        .o_carry    (w_carry),
        .o_overflow (w_unused_overflow)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_acc_nxt = r_acc;
        w_q_nxt   = r_q;
        if (r_mode == MODE_MUL) begin
            if (r_q[0]) begin
                {w_acc_nxt, w_q_nxt} = {w_carry, w_sum, r_q[WIDTH-1:1]};
            end else begin
                {w_acc_nxt, w_q_nxt} = {1'b0, r_acc, r_q[WIDTH-1:1]};
            end
        end else begin
            // Shifted-out remainder bit set means the 9-bit remainder already exceeds D.
            if (r_acc[WIDTH-1] || w_carry) begin
                w_acc_nxt = w_sum;
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_add_a;
                w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == CNT_LAST) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= MODE_MUL;
            r_m         <= '0;
            r_acc       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_result_hi <= '0;
            r_result_lo <= '0;
            r_dbz       <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_m    <= (mode == MODE_DIV) ? op_b : op_a;
                        r_q    <= (mode == MODE_DIV) ? op_a : op_b;
                    end
                end
                ST_LOAD: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_result_hi <= w_acc_nxt;
                        r_result_lo <= w_q_nxt;
                        r_dbz       <= (r_mode == MODE_DIV) && (r_m == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign result_hi   = r_result_hi;
    assign result_lo   = r_result_lo;
    assign div_by_zero = r_dbz;

endmodule : mul_div_seq_8bit

// File: tb/tb_mul_div_seq_8bit.sv
// Self-checking bench for mul_div_seq_8bit: directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_mul_div_seq_8bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic [7:0] result_hi;
    logic [7:0] result_lo;
    logic       div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mul_div_seq_8bit #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .result_hi   (result_hi),
        .result_lo   (result_lo),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {div_by_zero, hi, lo}.
    function automatic logic [16:0] model(input logic m, input logic [7:0] a, input logic [7:0] b);
        int unsigned ua = a;
        int unsigned ub = b;
        int unsigned p;
        if (!m) begin
            p = ua * ub;
            return {1'b0, p[15:0]};
        end
        if (ub == 0) return {1'b1, a, 8'hFF};
        p = ua % ub;
        ub = ua / ub;
        return {1'b0, p[7:0], ub[7:0]};
    endfunction

    task automatic run_op(input logic m, input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [16:0] exp;
        int n;
        exp = model(m, a, b);
        @(negedge clk);
        start = 1'b1; mode = m; op_a = a; op_b = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
        end while (!done && n < 30);
        check({tag, " latency"}, n, 10);
        check({tag, " result"}, {result_hi, result_lo}, exp[15:0]);
        check({tag, " dbz"}, div_by_zero, exp[16]);
        check({tag, " busy_at_done"}, busy, 1);
        @(negedge clk);
        check({tag, " hold"}, {done, busy, result_hi, result_lo}, {2'b00, exp[15:0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_done;
        int t_first;
        int t_second;
        int n;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; op_a = '0; op_b = '0;
        #1;
        check("reset outputs", {busy, done, result_hi, result_lo, div_by_zero}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset", {busy, done}, 0);

        run_op(1'b0, 8'd13, 8'd11, "mul 13x11");
        check("mul 13x11 literal", {result_hi, result_lo}, 16'h008F);
        run_op(1'b0, 8'hFF, 8'hFF, "mul ffxff");
        check("mul ffxff literal", {result_hi, result_lo}, 16'hFE01);
        run_op(1'b0, 8'h00, 8'hAB, "mul 0xab");
        run_op(1'b1, 8'd200, 8'd7, "div 200/7");
        check("div 200/7 literal", {result_hi, result_lo}, {8'd4, 8'd28});
        run_op(1'b1, 8'hFF, 8'h01, "div ff/01");
        run_op(1'b1, 8'h80, 8'h81, "div 80/81");
        run_op(1'b1, 8'hFF, 8'h81, "div ff/81");
        run_op(1'b1, 8'h5A, 8'h00, "div 5a/0");
        check("div 5a/0 literal", {div_by_zero, result_hi, result_lo}, {1'b1, 8'h5A, 8'hFF});
        run_op(1'b1, 8'h64, 8'h0A, "div after dbz");

        // start pulsed during RUN cycle 3 must be ignored
        @(negedge clk);
        start = 1'b1; mode = 1'b0; op_a = 8'd13; op_b = 8'd11;
        n = 0; n_done = 0;
        repeat (30) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (n == 5) begin start = 1'b1; op_a = 8'd3; op_b = 8'd3; end
            if (n == 6) start = 1'b0;
            if (done) n_done++;
            if (done) check("ignored start result", {result_hi, result_lo}, 16'h008F);
        end
        check("ignored start done count", n_done, 1);
        check("ignored start idle", busy, 0);

        // start held high: back-to-back operations
        @(negedge clk);
        start = 1'b1; mode = 1'b0; op_a = 8'd13; op_b = 8'd11;
        n = 0; t_first = -1; t_second = -1;
        while (t_second < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (done && t_first < 0) t_first = n;
            else if (done && t_second < 0) t_second = n;
        end
        check("held start spacing", t_second - t_first, 11);
        check("held start result", {result_hi, result_lo}, 16'h008F);
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        check("held start drains", busy, 0);

        // asynchronous reset during RUN cycle 4
        @(negedge clk);
        start = 1'b1; mode = 1'b0; op_a = 8'd200; op_b = 8'd100;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
        end
        check("busy before abort", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset outputs", {busy, done, result_hi, result_lo, div_by_zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("no done after abort", n_done, 0);
        run_op(1'b0, 8'd13, 8'd11, "mul after reset");

        for (int i = 0; i < 40; i++) begin
            logic       rm;
            logic [7:0] ra;
            logic [7:0] rb;
            rm = 1'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = (i % 10 == 9) ? 8'h00 : 8'($urandom);
            run_op(rm, ra, rb, $sformatf("rand%0d %s %0d,%0d", i, rm ? "div" : "mul", ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mul_div_seq_8bit
